serial_rx_msb: RTL
==================

SERIAL_RX_MSB -- requirements
Module: serial_rx_msb

Interface
REQ-001 The block SHALL have parameter DW, default 9, giving the data word width in bits.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the number of clk cycles per serial bit, legal values >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enb, input, 1 bit: enable; when low, FSM, counters and shift register hold.
REQ-006 The block SHALL have port sin, input, 1 bit: serial line, MSB-first frame, idle high.
REQ-007 The block SHALL have port data_out, output, DW bits: last correctly framed received word.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse when data_out has been updated.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 Frame SHALL be: start bit (0), then DW data bits MSB first, then stop bit (1); each bit lasts CLKS_PER_BIT cycles.
REQ-012 sin SHALL pass through a 2-flop synchronizer (sin_s) that is clocked every cycle regardless of enb; all FSM decisions SHALL use sin_s only.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; the FSM, bit counter cnt and bit index idx SHALL advance only in cycles with enb=1.
REQ-014 IDLE: if sin_s=0, go to START with cnt=0; otherwise stay in IDLE.
REQ-015 START: cnt increments each cycle; at cnt=CLKS_PER_BIT/2-1 (integer division), sample sin_s: if 0, go to DATA with cnt=0 and idx=0; if 1, treat as a false start and return to IDLE with no output pulse.
REQ-016 DATA: cnt increments; at cnt=CLKS_PER_BIT-1, sample sin_s, shift it in as sr <= {sr[DW-2:0], sin_s}, set cnt=0 and idx=idx+1; after the DW-th sample, go to STOP.
REQ-017 STOP: at cnt=CLKS_PER_BIT-1, sample sin_s: if 1, set data_out <= sr and pulse valid; if 0, pulse frame_err and leave data_out unchanged. In either case return to IDLE.
REQ-018 valid and frame_err SHALL be registered, high for exactly one cycle after the sampling edge, and cleared on the next edge regardless of enb; they are never high together.
REQ-019 The first received data bit SHALL land in data_out[DW-1] (MSB first).
REQ-020 From IDLE, a new start bit SHALL be accepted on the first cycle after returning to IDLE, so back-to-back frames with no idle gap are received.
REQ-021 cnt width SHALL be $clog2(CLKS_PER_BIT) and idx width $clog2(DW+1); neither shall wrap within a frame.
REQ-022 busy SHALL be combinationally derived from state (state != IDLE).

Reset
REQ-023 On reset=0, state=IDLE, cnt=0, idx=0, sr='0, data_out='0, valid=0, frame_err=0, and both synchronizer flops=1, all immediately and asynchronously.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse, and data_out SHALL read 0.
REQ-025 After reset release, the block SHALL not detect a start until sin_s first reads 0.

Verification (DW=9, CLKS_PER_BIT=4, enb=1 unless stated)
REQ-026 Send frame 9'h1A5 with stop=1 -> data_out=9'h1A5, valid high for 1 cycle, frame_err=0, busy low again after the stop sample.
REQ-027 Send 9'h0FF with stop=0 -> frame_err pulses once, valid=0, and data_out keeps its previous value.
REQ-028 Hold sin low for 1 cycle, then high -> START sees sin_s=1 at mid-bit, returns to IDLE, no pulses, data_out unchanged.
REQ-029 Send two frames 9'h155 then 9'h0AA with no idle gap -> two valid pulses with data_out=9'h155 then 9'h0AA.
REQ-030 Drop enb low for 3 cycles during data bit 4 while stretching sin by the same 3 cycles -> data_out is still correct and the valid pulse is delayed by 3 cycles.
REQ-031 Assert reset during data bit 5 of a frame -> all outputs read 0 immediately; a following clean frame 9'h001 is received correctly.

Source files
------------

// File: rtl/serial_rx_msb.sv
// serial_rx_msb -- MSB-first asynchronous serial receiver.
//
// Receives frames of: start bit (0), DW data bits MSB first, stop bit (1).
// Each bit lasts CLKS_PER_BIT clk cycles. The line is idle high.
//
// Parameters:
//   DW            data word width in bits (>= 2)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   reset      asynchronous, active-low reset
//   enb        enable; when low the FSM, counters and shift register hold
//   sin        serial input line (asynchronous to clk)
//   data_out   last correctly framed word
//   valid      one-cycle pulse when data_out has been updated
//   frame_err  one-cycle pulse when the stop bit read 0
//   busy       high whenever the FSM is not idle
module serial_rx_msb #(
    parameter int DW           = 9,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enb,
    input  logic          sin,
    output logic [DW-1:0] data_out,
    output logic          valid,
    output logic          frame_err,
    output logic          busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DW + 1);

    // Start bit is re-checked half a bit in; data/stop bits at the end of
    // each full bit period measured from that mid-start point.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    sr_q, sr_d;
    logic [DW-1:0]    data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;

    // Two-flop synchronizer; runs every cycle so sin_s stays current even
    // while enb is low. Resets to the idle line level.
    logic sin_meta_q;
    logic sin_s_q;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // case leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sr_d        = sr_q;
        data_out_d  = data_out_q;
        // Pulses drop on the next edge whether or not enb is high.
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (enb) begin
            unique case (state_q)
                IDLE: begin
                    if (!sin_s_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end

                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!sin_s_q) begin
                            state_d = DATA;
                            idx_d   = '0;
                        end else begin
                            // Line went back high: glitch, not a start bit.
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        sr_d  = {sr_q[DW-2:0], sin_s_q};
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        if (sin_s_q) begin
                            data_out_d = sr_q;
                            valid_d    = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments here so every flop updates from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sin_meta_q  <= 1'b1;
            sin_s_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sr_q        <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sin_meta_q  <= sin;
            sin_s_q     <= sin_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
